// File: rtl/axis_sched_pkg.sv
// Shared types for the frame-level AXI-Stream mux scheduler.
package axis_sched_pkg;

  localparam int NUM_SRC = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    XFER  = 2'd2
  } sched_state_t;

  typedef logic [1:0] mux_sel_t;

endpackage

// File: rtl/axis_mux_sched_rr_arb4.sv
// Combinational 4-way rotating-priority pick: first requesting source
// found when searching ptr, ptr+1, ... (mod 4).
module rr_arb4
  import axis_sched_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] gnt,
  output logic       any
);

  mux_sel_t idx;

  // Walk from the farthest offset down so the offset closest to ptr wins.
  always_comb begin
    gnt = ptr;
    any = 1'b0;
    idx = ptr;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      idx = ptr + mux_sel_t'(i);
      if (req[idx]) begin
        gnt = idx;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_mux_sched.sv
// Frame-level scheduler for the 4:1 AXI-Stream mux select. Selection only
// moves on frame boundaries; pass_en gates the mux output handshake.
//
//   state | meaning
//   IDLE  | no frame owned; pick next source when enabled
//   GRANT | mux_sel just changed; one settle cycle with pass_en low
//   XFER  | frame in flight; count beats until len_q reached
module axis_mux_sched
  import axis_sched_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             en,
  input  logic             mode,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             clr,
  input  logic [3:0]       in_tvalid,
  input  logic             mux_tvalid,
  input  logic             dn_tready,
  output logic [1:0]       mux_sel,
  output logic             pass_en,
  output logic             frame_done,
  output logic             busy
);

  sched_state_t     state_q, state_d;
  logic [LEN_W-1:0] len_q, beat_cnt_q;
  mux_sel_t         rr_ptr_q, last_sel_q;
  mux_sel_t         arb_gnt, pick;
  logic             arb_any, pick_ok, beat, last_beat;

  rr_arb4 u_arb (
    .req (in_tvalid),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .any (arb_any)
  );

  // Fixed mode steps blindly through sources; round-robin needs a valid requester.
  assign pick      = mode ? mux_sel_t'(last_sel_q + 2'd1) : arb_gnt;
  assign pick_ok   = en & (mode | arb_any);
  assign beat      = pass_en & mux_tvalid & dn_tready;
  assign last_beat = beat & (beat_cnt_q == (len_q - LEN_W'(1)));

  // State register.
  always_ff @(posedge aclk) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; clr overrides every transition.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (pick_ok) state_d = GRANT;
        GRANT:   state_d = XFER;
        XFER:    if (last_beat) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs decoded from registered state; frame_done also needs the live beat.
  always_comb begin
    pass_en    = (state_q == XFER);
    busy       = (state_q == GRANT) || (state_q == XFER);
    frame_done = last_beat & ~clr;
  end

  // Frame bookkeeping: select, length, beat count and arbitration pointers.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      mux_sel    <= 2'd0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      rr_ptr_q   <= 2'd0;
      last_sel_q <= 2'd3;
    end else if (clr) begin
      beat_cnt_q <= '0;
    end else if ((state_q == IDLE) && pick_ok) begin
      mux_sel    <= pick;
      len_q      <= (frame_len == '0) ? LEN_W'(1) : frame_len;
      beat_cnt_q <= '0;
    end else if ((state_q == XFER) && beat) begin
      if (last_beat) begin
        beat_cnt_q <= '0;
        last_sel_q <= mux_sel;
        rr_ptr_q   <= mux_sel + 2'd1;
      end else begin
        beat_cnt_q <= beat_cnt_q + LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_axis_mux_sched.sv
// Bench for axis_mux_sched: a frame-level reference model predicts every
// output each cycle; directed scenarios add frame/grant count checks.
module tb_axis_mux_sched;

  logic        aclk = 1'b0;
  logic        aresetn, en, mode, clr, mux_tvalid, dn_tready;
  logic [15:0] frame_len;
  logic [3:0]  in_tvalid;
  logic [1:0]  mux_sel;
  logic        pass_en, frame_done, busy;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: phase 0 idle, 1 settle, 2 transfer; beats remaining counts down.
  int m_phase = 0, m_left = 0, m_sel = 0, m_ptr = 0, m_last = 3;

  int n_done, n_beat;
  int grants[$];

  always #5 aclk = ~aclk;

  axis_mux_sched #(.LEN_W(16)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .en         (en),
    .mode       (mode),
    .frame_len  (frame_len),
    .clr        (clr),
    .in_tvalid  (in_tvalid),
    .mux_tvalid (mux_tvalid),
    .dn_tready  (dn_tready),
    .mux_sel    (mux_sel),
    .pass_en    (pass_en),
    .frame_done (frame_done),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rstn, input logic e, input logic md, input logic c,
                      input logic [15:0] len, input logic [3:0] tv, input logic rdy);
    int   pick;
    bit   found;
    logic exp_beat, exp_done, exp_pass, exp_busy;
    @(negedge aclk);
    aresetn    = rstn;
    en         = e;
    mode       = md;
    clr        = c;
    frame_len  = len;
    in_tvalid  = tv;
    dn_tready  = rdy;
    mux_tvalid = tv[m_sel];
    #1;
    exp_pass = (m_phase == 2);
    exp_busy = (m_phase != 0);
    exp_beat = exp_pass && tv[m_sel] && rdy;
    exp_done = exp_beat && (m_left == 1) && !c;
    check("mux_sel",    {30'b0, mux_sel},    m_sel);
    check("pass_en",    {31'b0, pass_en},    {31'b0, exp_pass});
    check("busy",       {31'b0, busy},       {31'b0, exp_busy});
    check("frame_done", {31'b0, frame_done}, {31'b0, exp_done});
    if (busy && !pass_en) grants.push_back(int'(mux_sel));
    if (frame_done) n_done++;
    if (pass_en && mux_tvalid && dn_tready) n_beat++;
    // advance the model across the coming rising edge
    if (!rstn) begin
      m_phase = 0; m_sel = 0; m_left = 0; m_ptr = 0; m_last = 3;
    end else if (c) begin
      m_phase = 0;
    end else begin
      case (m_phase)
        0: if (e) begin
          found = 0;
          pick  = 0;
          if (md) begin
            pick  = (m_last + 1) % 4;
            found = 1;
          end else begin
            for (int k = 0; k < 4; k++)
              if (!found && tv[(m_ptr + k) % 4]) begin
                pick  = (m_ptr + k) % 4;
                found = 1;
              end
          end
          if (found) begin
            m_sel   = pick;
            m_left  = (len == 16'd0) ? 1 : int'(len);
            m_phase = 1;
          end
        end
        1: m_phase = 2;
        default: if (exp_beat) begin
          m_left--;
          if (m_left == 0) begin
            m_last  = m_sel;
            m_ptr   = (m_sel + 1) % 4;
            m_phase = 0;
          end
        end
      endcase
    end
  endtask

  initial begin
    aresetn = 1'b0; en = 1'b0; mode = 1'b0; clr = 1'b0; frame_len = 16'd0;
    in_tvalid = 4'h0; mux_tvalid = 1'b0; dn_tready = 1'b0;
    @(posedge aclk);

    // reset held with everything requesting
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 16'd4, 4'hF, 1'b1);

    // round-robin, all sources valid, 4-beat frames
    grants.delete(); n_done = 0; n_beat = 0;
    repeat (30) step(1'b1, 1'b1, 1'b0, 1'b0, 16'd4, 4'hF, 1'b1);
    check("rr_frames", n_done, 5);
    check("rr_beats", n_beat, 20);
    check("rr_grant_cnt", grants.size(), 5);
    for (int i = 0; i < 5 && i < grants.size(); i++) check("rr_grant_order", grants[i], i % 4);

    // only source 2 valid, then source 0 joins mid-frame
    grants.delete();
    repeat (22) step(1'b1, 1'b1, 1'b0, 1'b0, 16'd3, 4'h4, 1'b1);
    check("solo_grant_cnt", grants.size(), 5);
    foreach (grants[i]) check("solo_grant_src", grants[i], 2);
    grants.delete();
    repeat (13) step(1'b1, 1'b1, 1'b0, 1'b0, 16'd3, 4'h5, 1'b1);
    check("join_grant_cnt", grants.size(), 2);
    if (grants.size() == 2) begin
      check("join_first", grants[0], 0);
      check("join_second", grants[1], 2);
    end

    // fixed order with source 1 stalled
    repeat (10) step(1'b1, 1'b1, 1'b1, 1'b0, 16'd2, 4'hD, 1'b1);
    n_done = 0;
    repeat (20) step(1'b1, 1'b1, 1'b1, 1'b0, 16'd2, 4'hD, 1'b1);
    check("stall_done", n_done, 0);
    check("stall_sel", {30'b0, mux_sel}, 1);
    check("stall_busy", {31'b0, busy}, 1);
    check("stall_beat_cnt", {16'b0, dut.beat_cnt_q}, 0);
    repeat (2) step(1'b1, 1'b1, 1'b1, 1'b0, 16'd2, 4'hF, 1'b1);
    check("stall_resume_done", n_done, 1);
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 16'd2, 4'hF, 1'b1);

    // backpressure on a 5-beat frame
    n_done = 0; n_beat = 0;
    for (int i = 0; i < 40 && n_done == 0; i++)
      step(1'b1, 1'b1, 1'b0, 1'b0, 16'd5, 4'h1, i[0]);
    check("bp_done", n_done, 1);
    check("bp_beats", n_beat, 5);
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 16'd5, 4'h1, 1'b1);

    // zero length means single-beat frames
    n_done = 0; n_beat = 0;
    repeat (9) step(1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 4'hF, 1'b1);
    check("len0_done", n_done, 3);
    check("len0_beats", n_beat, 3);

    // abort on the third beat of an 8-beat frame, then en drops mid-frame
    n_done = 0; grants.delete();
    repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0, 16'd8, 4'hF, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 16'd8, 4'hF, 1'b1);
    check("clr_no_done", n_done, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'd8, 4'hF, 1'b1);
    check("clr_idle_busy", {31'b0, busy}, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'd8, 4'hF, 1'b1);
    check("clr_regrant_cnt", grants.size(), 2);
    if (grants.size() == 2) check("clr_regrant_same", grants[1], grants[0]);
    repeat (12) step(1'b1, 1'b0, 1'b0, 1'b0, 16'd8, 4'hF, 1'b1);
    check("en_off_done", n_done, 1);
    check("en_off_busy", {31'b0, busy}, 0);

    // random traffic against the model
    for (int i = 0; i < 600; i++)
      step(($urandom % 64) != 0, ($urandom % 8) != 0, 1'($urandom % 2),
           ($urandom % 16) == 0, 16'($urandom % 6), 4'($urandom), 1'($urandom % 2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
